// File: rtl/lcd_s00_axi_slave.sv
// AXI4-Lite slave exposing four 32-bit control registers to the LCD datapath.
// Write address and write data are buffered independently and committed
// together; reads run on their own channel without stalling writes.
module lcd_s00_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    // write response channel
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    // register outputs to the LCD datapath
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
    output logic [3:0]                      reg_wr
);

    localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;

    // Response code is always OKAY
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_S_AXI_DATA_WIDTH-1:0] r_slv_reg [4];

    logic                          r_aw_full;
    logic [1:0]                    r_aw_idx;
    logic                          r_w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [NUM_LANES-1:0]          r_wstrb;
    logic                          r_bvalid;
    logic                          r_awready;
    logic                          r_wready;
    logic [3:0]                    r_reg_wr;

    logic                          r_arready;
    logic                          r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    // ------------------------------------------------------------------
    // Combinational write-path decode
    // ------------------------------------------------------------------
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_aw_have;
    logic                          w_w_have;
    logic                          w_commit;
    logic [1:0]                    w_wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_data;
    logic [NUM_LANES-1:0]          w_wr_strb;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_old;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_word;
    logic                          w_aw_full_nxt;
    logic                          w_w_full_nxt;
    logic                          w_bvalid_nxt;

    logic                          w_ar_hs;
    logic                          w_rvalid_nxt;

    // Address offset bits and protection attributes carry no meaning here
    logic                          w_unused_ok;
    assign w_unused_ok = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid  && r_wready;
    assign w_aw_have = r_aw_full || w_aw_hs;
    assign w_w_have  = r_w_full  || w_w_hs;
    assign w_commit  = w_aw_have && w_w_have && !r_bvalid;

    assign w_ar_hs   = s_axi_arvalid && r_arready;

    // Select buffered or live address/data for the commit and merge byte lanes
    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_wr_idx  = r_aw_full ? r_aw_idx : s_axi_awaddr[3:2];
        w_wr_data = r_w_full  ? r_wdata  : s_axi_wdata;
        w_wr_strb = r_w_full  ? r_wstrb  : s_axi_wstrb;
        w_wr_old  = r_slv_reg[w_wr_idx];
        w_wr_word = w_wr_old;
        for (int b = 0; b < NUM_LANES; b++) begin
            if (w_wr_strb[b]) begin
                w_wr_word[b*8 +: 8] = w_wr_data[b*8 +: 8];
            end
        end
    end

    // Next-state of the write buffers and the write response
    always_comb begin
        w_aw_full_nxt = w_aw_have;
        w_w_full_nxt  = w_w_have;
        w_bvalid_nxt  = r_bvalid;
        if (w_commit) begin
            w_aw_full_nxt = 1'b0;
            w_w_full_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b1;
        end else if (r_bvalid && s_axi_bready) begin
            w_bvalid_nxt  = 1'b0;
        end
    end

    // Next-state of the read response
    always_comb begin
        w_rvalid_nxt = r_rvalid;
        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
        end else if (r_rvalid && s_axi_rready) begin
            w_rvalid_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Write channel buffers, response and ready flags
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_reg_wr  <= '0;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_awready <= !w_aw_full_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_full_nxt  && !w_bvalid_nxt;
            r_reg_wr  <= w_commit ? (4'b0001 << w_wr_idx) : 4'b0000;
            if (w_aw_hs) begin
                r_aw_idx <= s_axi_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    // Register file update on commit
    // NOTE: the register file is reset because its contents drive the LCD
    // datapath directly; a large RAM would normally be left unreset.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            for (int i = 0; i < 4; i++) begin
                r_slv_reg[i] <= '0;
            end
        end else if (w_commit) begin
            r_slv_reg[w_wr_idx] <= w_wr_word;
        end
    end

    // Read channel: capture pre-edge register value on the AR handshake
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= r_slv_reg[s_axi_araddr[3:2]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = RESP_OKAY;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = RESP_OKAY;

    assign slv_reg0 = r_slv_reg[0];
    assign slv_reg1 = r_slv_reg[1];
    assign slv_reg2 = r_slv_reg[2];
    assign slv_reg3 = r_slv_reg[3];
    assign reg_wr   = r_reg_wr;

endmodule

// File: tb/tb_lcd_s00_axi_slave.sv
// Directed bench for the LCD AXI4-Lite register slave.
module tb_lcd_s00_axi_slave;

    logic        s_axi_aclk;
    logic        s_axi_areset;
    logic [3:0]  s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] slv_reg0;
    logic [31:0] slv_reg1;
    logic [31:0] slv_reg2;
    logic [31:0] slv_reg3;
    logic [3:0]  reg_wr;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_s00_axi_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_areset  (s_axi_areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .slv_reg0      (slv_reg0),
        .slv_reg1      (slv_reg1),
        .slv_reg2      (slv_reg2),
        .slv_reg3      (slv_reg3),
        .reg_wr        (reg_wr)
    );

    initial s_axi_aclk = 1'b0;
    always #5 s_axi_aclk = ~s_axi_aclk;

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 ns after the rising edge
    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reg0"},    slv_reg0, 32'h0);
        check({tag, "_reg1"},    slv_reg1, 32'h0);
        check({tag, "_reg2"},    slv_reg2, 32'h0);
        check({tag, "_reg3"},    slv_reg3, 32'h0);
        check({tag, "_awready"}, {31'b0, s_axi_awready}, 32'h0);
        check({tag, "_wready"},  {31'b0, s_axi_wready},  32'h0);
        check({tag, "_arready"}, {31'b0, s_axi_arready}, 32'h0);
        check({tag, "_bvalid"},  {31'b0, s_axi_bvalid},  32'h0);
        check({tag, "_rvalid"},  {31'b0, s_axi_rvalid},  32'h0);
        check({tag, "_rdata"},   s_axi_rdata, 32'h0);
        check({tag, "_reg_wr"},  {28'b0, reg_wr}, 32'h0);
    endtask

    task automatic do_reset();
        s_axi_areset = 1'b1;
        tick();
        tick();
        s_axi_areset = 1'b0;
        tick();
    endtask

    // Full write with both channels presented together and bready=1
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [3:0] wr_seen);
        logic aw_done;
        logic w_done;
        logic aw_hs;
        logic w_hs;
        int   cyc;
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid  && s_axi_wready;
            tick();
            cyc++;
            if (aw_hs) begin
                s_axi_awvalid = 1'b0;
                aw_done = 1'b1;
            end
            if (w_hs) begin
                s_axi_wvalid = 1'b0;
                w_done = 1'b1;
            end
        end
        while (!s_axi_bvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (cyc >= 20) begin
            check("write_timeout", 32'(cyc), 32'(0));
        end
        wr_seen = reg_wr;
        check("write_bresp", {30'b0, s_axi_bresp}, 32'h0);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        logic ar_hs;
        int   cyc;
        cyc   = 0;
        ar_hs = 1'b0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        while (!ar_hs && cyc < 20) begin
            ar_hs = s_axi_arvalid && s_axi_arready;
            tick();
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        while (!s_axi_rvalid && cyc < 20) begin
            tick();
            cyc++;
        end
        if (cyc >= 20) begin
            check("read_timeout", 32'(cyc), 32'(0));
        end
        data = s_axi_rdata;
        check("read_rresp", {30'b0, s_axi_rresp}, 32'h0);
        tick();
    endtask

    logic [3:0]  wr_seen;
    logic [31:0] rd;
    logic [31:0] exp_reg [4];
    logic [3:0]  exp_onehot [4];

    initial begin
        s_axi_areset  = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = 3'b010;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arprot  = 3'b101;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        exp_reg[0] = 32'h1;  exp_reg[1] = 32'h2;
        exp_reg[2] = 32'h3;  exp_reg[3] = 32'h4;
        exp_onehot[0] = 4'b0001; exp_onehot[1] = 4'b0010;
        exp_onehot[2] = 4'b0100; exp_onehot[3] = 4'b1000;

        // Reset state
        tick();
        tick();
        check_all_zero("rst");
        s_axi_areset = 1'b0;
        tick();
        check("rst_exit_awready", {31'b0, s_axi_awready}, 32'h1);
        check("rst_exit_wready",  {31'b0, s_axi_wready},  32'h1);
        check("rst_exit_arready", {31'b0, s_axi_arready}, 32'h1);

        // Basic writes then reads of all four registers
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), exp_reg[i], 4'hF, wr_seen);
            check($sformatf("basic_reg_wr%0d", i), {28'b0, wr_seen}, {28'b0, exp_onehot[i]});
            check($sformatf("basic_pulse_end%0d", i), {28'b0, reg_wr}, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check($sformatf("basic_rdata%0d", i), rd, exp_reg[i]);
        end
        // Address offset bits are ignored
        axi_read(4'h7, rd);
        check("offset_ignored", rd, 32'h2);

        // W three cycles ahead of AW
        s_axi_wdata  = 32'hDEADBEEF;
        s_axi_wstrb  = 4'hF;
        s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b0;
        tick();
        s_axi_wvalid = 1'b0;
        check("wfirst_wready_low", {31'b0, s_axi_wready},  32'h0);
        check("wfirst_awready",    {31'b0, s_axi_awready}, 32'h1);
        tick();
        tick();
        check("wfirst_no_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
        check("wfirst_no_commit", slv_reg2, 32'h3);
        s_axi_awaddr  = 4'h8;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("wfirst_reg2",   slv_reg2, 32'hDEADBEEF);
        check("wfirst_bvalid", {31'b0, s_axi_bvalid}, 32'h1);
        check("wfirst_reg_wr", {28'b0, reg_wr}, 32'h4);
        s_axi_bready = 1'b1;
        tick();
        check("wfirst_bdone",   {31'b0, s_axi_bvalid},  32'h0);
        check("wfirst_awready_back", {31'b0, s_axi_awready}, 32'h1);

        // Partial byte-lane write
        axi_write(4'h4, 32'hAABBCCDD, 4'hF, wr_seen);
        check("strb_full", slv_reg1, 32'hAABBCCDD);
        axi_write(4'h4, 32'h11223344, 4'b0011, wr_seen);
        check("strb_low2", slv_reg1, 32'hAABB3344);

        // Empty strobe: OKAY, no change, still pulses
        axi_write(4'h4, 32'hFFFFFFFF, 4'b0000, wr_seen);
        check("strb0_unchanged", slv_reg1, 32'hAABB3344);
        check("strb0_reg_wr", {28'b0, wr_seen}, 32'h2);

        // Back-pressure on the B channel
        s_axi_bready  = 1'b0;
        s_axi_awaddr  = 4'hC;
        s_axi_wdata   = 32'h100;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        check("bp_first_commit", slv_reg3, 32'h100);
        check("bp_bvalid", {31'b0, s_axi_bvalid}, 32'h1);
        s_axi_awaddr = 4'h0;
        s_axi_wdata  = 32'h200;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_bvalid%0d", i), {31'b0, s_axi_bvalid}, 32'h1);
            check($sformatf("bp_hold_rdy%0d", i), {30'b0, s_axi_awready, s_axi_wready}, 32'h0);
        end
        check("bp_no_second", slv_reg0, 32'h1);
        s_axi_bready = 1'b1;
        tick();
        check("bp_released", {31'b0, s_axi_bvalid}, 32'h0);
        check("bp_still_old", slv_reg0, 32'h1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("bp_second_commit", slv_reg0, 32'h200);
        check("bp_second_reg_wr", {28'b0, reg_wr}, 32'h1);
        check("bp_second_bvalid", {31'b0, s_axi_bvalid}, 32'h1);
        tick();
        check("bp_once_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
        check("bp_once_reg_wr", {28'b0, reg_wr}, 32'h0);
        tick();
        check("bp_once_idle", {31'b0, s_axi_bvalid}, 32'h0);

        // Read and commit to the same register at the same edge
        s_axi_rready  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = 4'h4;
        s_axi_arvalid = 1'b1;
        s_axi_awaddr  = 4'h4;
        s_axi_wdata   = 32'h55;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("raw_rvalid", {31'b0, s_axi_rvalid}, 32'h1);
        check("raw_old_value", s_axi_rdata, 32'hAABB3344);
        check("raw_reg1_new", slv_reg1, 32'h55);
        check("raw_bvalid", {31'b0, s_axi_bvalid}, 32'h1);
        tick();
        tick();
        check("raw_rdata_stable", s_axi_rdata, 32'hAABB3344);
        check("raw_arready_low", {31'b0, s_axi_arready}, 32'h0);
        s_axi_rready = 1'b1;
        tick();
        check("raw_rdone", {31'b0, s_axi_rvalid}, 32'h0);
        check("raw_arready_back", {31'b0, s_axi_arready}, 32'h1);
        axi_read(4'h4, rd);
        check("raw_reread", rd, 32'h55);

        // Reset after a lone AW
        s_axi_awaddr  = 4'h0;
        s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("midrst_aw_held", {30'b0, s_axi_awready, s_axi_wready}, 32'h1);
        s_axi_areset = 1'b1;
        tick();
        check_all_zero("midrst");
        s_axi_areset = 1'b0;
        tick();
        check("midrst_ready", {29'b0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        s_axi_wdata  = 32'h77;
        s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_lone_w_bvalid", {31'b0, s_axi_bvalid}, 32'h0);
        check("midrst_lone_w_reg0", slv_reg0, 32'h0);
        check("midrst_lone_w_reg_wr", {28'b0, reg_wr}, 32'h0);
        do_reset();
        axi_write(4'h0, 32'h99, 4'hF, wr_seen);
        check("postrst_reg_wr", {28'b0, wr_seen}, 32'h1);
        check("postrst_reg0", slv_reg0, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
